// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive controller.
// Finds the start edge, drives the external edge/bit counter, majority-votes
// three mid-bit oversamples, deserializes 8 data bits LSB-first, checks
// optional parity and the stop bit, and reports each frame with one-cycle
// status pulses.
module uart_rx_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  output logic       edge_cnt_en,
  output logic       cnt_clr,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned PSC_W         = 6;
  localparam int unsigned BIT_W         = 4;
  localparam int unsigned FRM_W         = 9;
  localparam int unsigned LAST_DATA_BIT = 8;
  // Longest legal frame (start + 8 data + parity + stop at 32x oversampling).
  localparam int unsigned FRAME_MAX     = 11 * 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Frame datapath registers
  logic              s0;
  logic              s1;
  logic              sampled_bit;
  logic              par_en_q;
  logic              par_typ_q;
  logic [DATA_W-1:0] shift_reg;
  logic              par_fail;
  logic [FRM_W-1:0]  frame_cnt;

  // Next values for the registered outputs
  logic              edge_cnt_en_d;
  logic              cnt_clr_d;
  logic [DATA_W-1:0] p_data_d;
  logic              data_valid_d;
  logic              par_err_d;
  logic              stp_err_d;

  // Bit-position decode, done at prescale width
  logic [PSC_W-1:0] edge_ext;
  logic [PSC_W-1:0] bit_last;
  logic [PSC_W-1:0] half;
  logic             bit_end;
  logic             at_s0;
  logic             at_s1;
  logic             at_s2;
  logic             start_det;
  logic             last_data;
  logic             timeout;
  logic             majority;

  assign edge_ext  = {1'b0, edge_cnt};
  assign bit_last  = prescale - PSC_W'(1);
  assign half      = prescale >> 1;
  assign bit_end   = (edge_ext == bit_last);
  assign at_s0     = (edge_ext == half - PSC_W'(1));
  assign at_s1     = (edge_ext == half);
  assign at_s2     = (edge_ext == half + PSC_W'(1));
  assign start_det = (state == S_IDLE) && !rx_in;
  assign last_data = (bit_cnt == BIT_W'(LAST_DATA_BIT));
  // Guards against prescale values whose bit end is never reached.
  assign timeout   = (frame_cnt == FRM_W'(FRAME_MAX - 1));
  assign majority  = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!rx_in) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = sampled_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && last_data) begin
          state_next = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // A frame that has overstayed the longest legal length is abandoned silently.
    if ((state != S_IDLE) && (state_next != S_IDLE) && timeout) begin
      state_next = S_IDLE;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    edge_cnt_en_d = (state_next != S_IDLE);
    cnt_clr_d     = (state_next == S_IDLE);
    p_data_d      = p_data;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    if ((state == S_STOP) && bit_end) begin
      stp_err_d = ~sampled_bit;
      par_err_d = par_fail;
      if (sampled_bit && !par_fail) begin
        data_valid_d = 1'b1;
        p_data_d     = shift_reg;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_en <= 1'b0;
      cnt_clr     <= 1'b1;
      p_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      edge_cnt_en <= edge_cnt_en_d;
      cnt_clr     <= cnt_clr_d;
      p_data      <= p_data_d;
      data_valid  <= data_valid_d;
      par_err     <= par_err_d;
      stp_err     <= stp_err_d;
    end
  end

  // Mid-bit oversampling and majority vote
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b0;
    end else if (state != S_IDLE) begin
      if (at_s0) begin
        s0 <= rx_in;
      end
      if (at_s1) begin
        s1 <= rx_in;
      end
      if (at_s2) begin
        sampled_bit <= majority;
      end
    end
  end

  // Frame configuration, frozen for the duration of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (start_det) begin
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  // Data deserializer, LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if ((state == S_DATA) && bit_end) begin
      shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};
    end
  end

  // Parity check result, held until the stop bit reports it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_fail <= 1'b0;
    end else if (start_det) begin
      par_fail <= 1'b0;
    end else if ((state == S_PARITY) && bit_end) begin
      par_fail <= (sampled_bit != ((^shift_reg) ^ par_typ_q));
    end
  end

  // Cycles spent in the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (state == S_IDLE) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FRM_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed bench for uart_rx_fsm with a behavioural model
// of the upstream edge/bit counter.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       edge_cnt_en;
  logic       cnt_clr;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int         cyc = 0;
  int         start_cyc = 0;
  int         idle_cyc = 0;
  int         dv_cyc = 0;
  int         dv_cnt = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;
  int         wide_cnt = 0;
  logic       en_prev = 1'b0;
  logic       dv_prev = 1'b0;
  logic       pe_prev = 1'b0;
  logic       se_prev = 1'b0;
  logic [7:0] rx_log [0:15];
  int         log_n = 0;

  // Baselines for per-test deltas
  int b_dv;
  int b_pe;
  int b_se;
  int b_log;

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .edge_cnt_en (edge_cnt_en),
    .cnt_clr     (cnt_clr),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream edge/bit counter model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= 4'd0;
    end else if (cnt_clr) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= 4'd0;
    end else if (edge_cnt_en) begin
      if ({1'b0, edge_cnt} == prescale - 6'd1) begin
        edge_cnt <= 5'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end
    end
  end

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (edge_cnt_en && !en_prev) start_cyc = cyc;
      if (!edge_cnt_en && en_prev) idle_cyc = cyc;
      if (data_valid) begin
        dv_cnt = dv_cnt + 1;
        dv_cyc = cyc;
        if (log_n < 16) rx_log[log_n] = p_data;
        log_n = log_n + 1;
      end
      if (par_err) pe_cnt = pe_cnt + 1;
      if (stp_err) se_cnt = se_cnt + 1;
      if ((data_valid && dv_prev) || (par_err && pe_prev) || (stp_err && se_prev))
        wide_cnt = wide_cnt + 1;
    end
    en_prev = edge_cnt_en;
    dv_prev = data_valid;
    pe_prev = par_err;
    se_prev = stp_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_dv  = dv_cnt;
    b_pe  = pe_cnt;
    b_se  = se_cnt;
    b_log = log_n;
  endtask

  // One line bit of p cycles; sample position flip_j is inverted (-1 = none)
  task automatic line_bit(input logic v, input int p, input int flip_j);
    for (int j = 0; j < p; j++) begin
      @(negedge clk);
      rx_in = (j == flip_j) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int flip_bit);
    int p;
    p = int'(prescale);
    line_bit(1'b0, p, -1);
    for (int i = 0; i < 8; i++)
      line_bit(d[i], p, (i == flip_bit) ? (p / 2 + 1) : -1);
    if (pe) line_bit(pbit, p, -1);
    line_bit(sbit, p, -1);
    rx_in = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_edge_cnt_en", 32'(edge_cnt_en), 32'h0);
    check("rst_cnt_clr",     32'(cnt_clr),     32'h1);
    check("rst_p_data",      32'(p_data),      32'h00);
    check("rst_pulses",      32'({data_valid, par_err, stp_err}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame, prescale 8, no parity
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("clean_dv",      32'(dv_cnt - b_dv), 32'd1);
    check("clean_p_data",  32'(p_data),        32'hA5);
    check("clean_errs",    32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    check("clean_latency", 32'(dv_cyc - start_cyc), 32'd80);

    // Even parity, correct parity bit
    prescale = 6'd16;
    par_en   = 1'b1;
    par_typ  = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("evenpar_dv",      32'(dv_cnt - b_dv), 32'd1);
    check("evenpar_p_data",  32'(p_data),        32'h3C);
    check("evenpar_latency", 32'(dv_cyc - start_cyc), 32'd176);
    check("evenpar_par_err", 32'(pe_cnt - b_pe), 32'd0);

    // Even parity, wrong parity bit
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("badpar_par_err", 32'(pe_cnt - b_pe), 32'd1);
    check("badpar_dv",      32'(dv_cnt - b_dv), 32'd0);
    check("badpar_stp_err", 32'(se_cnt - b_se), 32'd0);
    check("badpar_p_data",  32'(p_data),        32'h3C);

    // Stop error, prescale 32, odd parity correct
    prescale = 6'd32;
    par_typ  = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("stperr_stp_err", 32'(se_cnt - b_se), 32'd1);
    check("stperr_par_err", 32'(pe_cnt - b_pe), 32'd0);
    check("stperr_dv",      32'(dv_cnt - b_dv), 32'd0);
    check("stperr_p_data",  32'(p_data),        32'h3C);

    // Start glitch of 3 cycles, prescale 16
    prescale = 6'd16;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_time",   32'(idle_cyc - start_cyc), 32'd16);
    check("glitch_pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    check("glitch_p_data", 32'(p_data), 32'h3C);

    // Single-sample inversion inside data bit 3
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3);
    repeat (4) @(negedge clk);
    check("noise_dv",     32'(dv_cnt - b_dv), 32'd1);
    check("noise_p_data", 32'(p_data),        32'h5A);

    // Parity config changed mid-frame must be ignored
    prescale = 6'd8;
    repeat (2) @(negedge clk);
    snap();
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
      begin
        repeat (30) @(negedge clk);
        par_en  = 1'b1;
        par_typ = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("cfg_dv",      32'(dv_cnt - b_dv), 32'd1);
    check("cfg_p_data",  32'(p_data),        32'hC3);
    check("cfg_latency", 32'(dv_cyc - start_cyc), 32'd80);
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back frames with no idle gap
    snap();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);
    check("b2b_dv", 32'(dv_cnt - b_dv), 32'd2);
    if (b_log + 1 < 16) begin
      check("b2b_byte0", 32'(rx_log[b_log]),     32'h01);
      check("b2b_byte1", 32'(rx_log[b_log + 1]), 32'h80);
    end

    // Illegal prescale: bit end never reached, FSM must recover
    prescale = 6'd40;
    repeat (2) @(negedge clk);
    snap();
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (400) @(negedge clk);
    check("illegal_recover",
          32'((idle_cyc > start_cyc) && ((idle_cyc - start_cyc) <= 354)), 32'h1);
    check("illegal_pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    check("illegal_idle",   32'({edge_cnt_en, cnt_clr}), 32'h1);

    // Reset in the middle of the data bits
    prescale = 6'd16;
    repeat (2) @(negedge clk);
    snap();
    line_bit(1'b0, 16, -1);
    line_bit(1'b1, 16, -1);
    line_bit(1'b0, 16, -1);
    line_bit(1'b1, 16, -1);
    check("midrst_busy", 32'(edge_cnt_en), 32'h1);
    @(negedge clk);
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    check("midrst_en",     32'(edge_cnt_en), 32'h0);
    check("midrst_clr",    32'(cnt_clr),     32'h1);
    check("midrst_p_data", 32'(p_data),      32'h00);
    check("midrst_pulses", 32'({data_valid, par_err, stp_err}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_nopulse", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("postrst_dv",     32'(dv_cnt - b_dv), 32'd1);
    check("postrst_p_data", 32'(p_data),        32'h96);

    // Every status pulse was exactly one cycle wide
    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side controller for the UART RX path; sits directly downstream of the RX edge/bit counter and consumes its `edge_cnt`/`bit_cnt` outputs. It detects the start edge and enables and clears the counter. It majority-votes three oversamples per bit, deserializes 8 data bits LSB-first, checks optional parity and the stop bit, and presents the byte to the RX output interface with one-cycle status pulses.

## Interface
- No parameters; data width fixed at 8, oversampling set at runtime by `prescale`.
- `clk` in 1: system clock (RX oversampling clock).
- `rst` in 1: asynchronous reset, active-high.
- `rx_in` in 1: serial line, idle high; already synchronised upstream.
- `prescale` in 6: oversamples per bit; legal values 8, 16, 32.
- `par_en` in 1: 1 = frame carries a parity bit.
- `par_typ` in 1: 0 = even, 1 = odd.
- `edge_cnt` in 5: from edge counter; 0..prescale-1 within current bit.
- `bit_cnt` in 4: from edge counter; 0 = start, 1..8 = data, 9 = parity (par_en) or stop, 10 = stop (par_en).
- `edge_cnt_en` out 1: counter enable.
- `cnt_clr` out 1: synchronous clear to the edge counter; holds `edge_cnt`/`bit_cnt` at 0.
- `p_data` out 8: last good received byte.
- `data_valid` out 1: one-cycle pulse, `p_data` updated this cycle.
- `par_err` out 1: one-cycle pulse, parity mismatch on the frame just ended.
- `stp_err` out 1: one-cycle pulse, stop bit sampled 0.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP. Encoding is free.
- **Outputs per state:**
  - IDLE: `cnt_clr`=1, `edge_cnt_en`=0.
  - All other states: `cnt_clr`=0, `edge_cnt_en`=1.
- **Bit end:** `edge_cnt == prescale-1`. The compare is done at 6-bit width as {1'b0, edge_cnt} == prescale-1.
- **Sampling:**
  - Capture `rx_in` at `edge_cnt` = prescale/2-1, prescale/2 and prescale/2+1.
  - On the prescale/2+1 cycle, register `sampled_bit` = majority(s0, s1, current `rx_in`).
  - All decisions at bit end use this `sampled_bit`.
- **Transitions:**
  - IDLE → START: `rx_in`==0. On entry, latch `par_en` and `par_typ` into frame-config registers; mid-frame changes to these inputs are ignored.
  - START, at bit end: `sampled_bit`==0 → DATA; otherwise glitch → IDLE. A glitch produces no pulses and leaves `p_data` unchanged.
  - DATA, at each bit end: shift right, inserting `sampled_bit` at bit 7, so the first data bit lands in bit 0 after 8 shifts. At the bit end where `bit_cnt`==8, go to PARITY if latched `par_en`, else STOP.
  - PARITY, at bit end: register `par_fail` = `sampled_bit` != (^shift_reg XOR latched `par_typ`), then → STOP.
  - STOP, at bit end: → IDLE and emit status for the frame.
    - `stp_err` = ~`sampled_bit`.
    - `par_err` = `par_fail` (0 when parity is disabled).
    - If neither error: `p_data` ← shift_reg and `data_valid`=1.
- **Error frames:** `data_valid`=0 and `p_data` holds its previous value. `par_err` and `stp_err` may pulse together.
- **`par_fail`:** cleared on START entry.
- **Illegal `prescale`:** values outside 8/16/32 give undefined data. The FSM must still return to IDLE within 11 × 32 + 2 cycles of `rx_in` held high.

## Timing
- **Reset values:** state IDLE, `edge_cnt_en`=0, `cnt_clr`=1, `p_data`=8'h00, `data_valid`=0, `par_err`=0, `stp_err`=0. Internal shift, sample and config registers are 0.
- **Reset mid-frame:** immediate return to the reset values; no pulse is emitted.
- **Start latency:** a fall of `rx_in` sampled in cycle t puts the FSM in START at t+1, with `edge_cnt`=0 at t+1. Frame timing is referenced from t+1.
- **Frame length:** 10 × prescale cycles from START entry to the status pulse without parity, 11 × prescale with parity.
  - The status pulse is the first cycle of IDLE: the pulse outputs are registered and asserted in the cycle after STOP bit end.
- **Pulses:** all three are exactly 1 cycle wide, always deasserted the next cycle.
- **Back-to-back frames:** a start edge present in the first IDLE cycle is accepted. START is entered in the following cycle, at most 2 cycles late, which is within margin for prescale ≥ 8.

## Test plan
- **Clean frame:** prescale=8, par_en=0, send 8'hA5 → `data_valid` pulse 80 cycles after START entry, `p_data`=8'hA5, no errors.
- **Even parity:** prescale=16, par_en=1, par_typ=0, send 8'h3C with parity 0 → `data_valid`, `p_data`=8'h3C, 176 cycles. Repeat with parity 1 → `par_err`=1, `data_valid`=0, `p_data` unchanged.
- **Stop error:** prescale=32, odd parity, send 8'hFF with correct parity 1 and stop=0 → `stp_err`=1, `par_err`=0, no `data_valid`.
- **Glitch and noise:**
  - Low pulse of 3 cycles on `rx_in` with prescale=16 → return to IDLE after 16 cycles, no pulses.
  - Single-cycle inversion at mid-bit sample prescale/2 in a data bit → byte still correct (majority vote).
- **Back-to-back and reset:** two frames 8'h01, 8'h80 with no idle gap → two `data_valid` pulses, bytes correct. Assert `rst` mid-DATA → all outputs at reset values, the next frame is received correctly.
